// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// Latency: n/a (package).
// Backpressure: n/a (package).
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   // funct3 encodings of the M extension
   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Architectural results for the divide corner cases
   localparam logic [XLEN_DEF-1:0] DIV_ZERO_Q = '1;
   localparam logic [XLEN_DEF-1:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide, one bit per step.
// Latency: XLEN steps after load; hi:lo then holds product (mul) or remainder:quotient (div).
// Backpressure: none; advances only when step is high, loads when load is high.
// Ports: clk/Reset, load + div_mode + load_lo/load_b (initial operands), step, hi/lo (state).
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            load,
   input  logic            step,
   input  logic            div_mode,
   input  logic [XLEN-1:0] load_lo,
   input  logic [XLEN-1:0] load_b,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   logic [XLEN-1:0] b;
   logic            mode;
   logic [XLEN+1:0] x, y, s;
   logic [XLEN-1:0] shl;
   logic            ge;

   // Single adder: multiply adds the multiplicand into hi when the
   // multiplier LSB is set; divide subtracts the divisor from the partial
   // remainder shifted left by one with the next dividend bit.
   always_comb begin
      shl = {hi[XLEN-2:0], lo[XLEN-1]};
      if (mode) begin
         x = {1'b0, hi, lo[XLEN-1]};
         y = ~{2'b00, b};
      end else begin
         x = {2'b00, hi};
         y = lo[0] ? {2'b00, b} : '0;
      end
      s  = x + y + {{(XLEN+1){1'b0}}, mode};
      ge = ~s[XLEN+1];
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         hi   <= '0;
         lo   <= '0;
         b    <= '0;
         mode <= 1'b0;
      end else if (load) begin
         hi   <= '0;
         lo   <= load_lo;
         b    <= load_b;
         mode <= div_mode;
      end else if (step) begin
         if (mode) begin
            // restoring divide: keep the difference only when it did not go negative
            hi <= ge ? s[XLEN-1:0] : shl;
            lo <= {lo[XLEN-2:0], ge};
         end else begin
            // shift-add multiply: carry-out of the add shifts into hi MSB
            hi <= s[XLEN:1];
            lo <= {s[0], lo[XLEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling and divide corner cases around the datapath.
// Latency: done 33 cycles after start for normal ops, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall holds the core while iterating; start while busy is ignored.
// Ports: clk/Reset, start/funct3/rs1_data/rs2_data/rd_in in; stall, busy, done, result, rd_out out.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int              CW   = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op;
   logic            neg, special;
   logic [XLEN-1:0] spec_res;

   logic            s1_signed, s2_signed, is_rem, a_neg, b_neg;
   logic            div_zero, div_ovf, special_in, neg_in;
   logic [XLEN-1:0] a_mag, b_mag, spec_val;
   logic [XLEN-1:0] hi, lo, div_raw, div_res, mul_res, final_res;
   logic [2*XLEN-1:0] prod;
   logic            load, step;

   // Operand decode at issue time
   always_comb begin
      s1_signed = 1'b0;
      s2_signed = 1'b0;
      case (funct3)
         F3_MULH, F3_DIV, F3_REM: begin
            s1_signed = 1'b1;
            s2_signed = 1'b1;
         end
         F3_MULHSU: s1_signed = 1'b1;
         F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
         end
      endcase
      is_rem   = funct3[2] & funct3[1];
      a_neg    = s1_signed & rs1_data[XLEN-1];
      b_neg    = s2_signed & rs2_data[XLEN-1];
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      a_mag    = a_neg ? -rs1_data : rs1_data;
      b_mag    = b_neg ? -rs2_data : rs2_data;
      // remainder follows the dividend; everything else follows the sign product
      neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
      div_zero = (rs2_data == '0);
      div_ovf  = s1_signed & funct3[2] & (rs1_data == SMIN) & (rs2_data == '1);
      special_in = funct3[2] & (div_zero | div_ovf);
      if (is_rem) spec_val = div_zero ? rs1_data : '0;
      else        spec_val = div_zero ? DIV_ZERO_Q : DIV_OVF_Q;
   end

   assign load  = (state == ST_IDLE) & start & ~special_in;
   assign step  = (state == ST_RUN);
   assign stall = ((state == ST_IDLE) & start) | (state == ST_RUN);

   muldiv_datapath #(.XLEN(XLEN)) u_dp (
      .clk      (clk),
      .Reset    (Reset),
      .load     (load),
      .step     (step),
      .div_mode (funct3[2]),
      .load_lo  (funct3[2] ? a_mag : b_mag),
      .load_b   (funct3[2] ? b_mag : a_mag),
      .hi       (hi),
      .lo       (lo)
   );

   // Final sign fix-up and word select
   always_comb begin
      prod = {hi, lo};
      if (neg) prod = -prod;
      mul_res   = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_raw   = op[1] ? hi : lo;
      div_res   = neg ? -div_raw : div_raw;
      final_res = op[2] ? div_res : mul_res;
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         rd_out   <= '0;
         op       <= '0;
         neg      <= 1'b0;
         special  <= 1'b0;
         spec_res <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op       <= funct3;
                  rd_out   <= rd_in;
                  neg      <= neg_in;
                  special  <= special_in;
                  spec_res <= spec_val;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= special_in ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1)) state <= ST_DONE;
            end
            ST_DONE: begin
               done   <= 1'b1;
               result <= special ? spec_res : final_res;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit that consumes the two register-file read operands and produces a write-back value plus a destination register index. Sits between the register-file read ports and the write-data mux. Holds the core via stall while an M-extension instruction iterates, then issues a one-cycle write-back strobe. Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
start  input  1  decoded M-extension instruction valid (opcode 0110011, funct7 0000001).
funct3  input  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
rs1_data  input  XLEN  operand A (register-file Data1).
rs2_data  input  XLEN  operand B (register-file Data2).
rd_in  input  5  destination register index.
stall  output  1  combinational: start in IDLE, or state RUN. Freezes PC and fetch.
busy  output  1  registered: high in RUN and DONE.
done  output  1  registered one-cycle write-back strobe, used as RegWrite for this path.
result  output  XLEN  write-back value, valid when done; held until next accepted start.
rd_out  output  5  destination index latched at start.

Behaviour:
- Reset low (any time, including mid-operation): state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Partial results are discarded; no write-back.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches funct3, rd_in, |rs1|, |rs2| (signedness per op), and result-sign flags. Normal case -> RUN, counter=0. Special divide cases -> DONE directly.
- RUN: one iteration per cycle. After XLEN iterations (counter==XLEN-1), -> DONE.
- DONE: done=1 for exactly one cycle, result and rd_out valid, then -> IDLE.
- Latency: start sampled at edge 0. Normal ops give done high in the cycle after edge XLEN+1 (33 cycles). Special cases give done after edge 1.
- start asserted while busy is ignored; no queueing.
- Multiply: 2*XLEN-bit unsigned product of magnitudes, negated if the sign flag is set.
  - MUL returns the low word.
  - MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; MULHU: both unsigned. These return the high word.
- Divide (restoring): unsigned quotient/remainder of magnitudes.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Divide by zero (rs2==0): quotient = all ones; remainder = rs1 unmodified. Resolved in IDLE, no RUN.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient 0x80000000, remainder 0. Resolved in IDLE.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000 (XLEN-bit, no overflow in the datapath).
- Operands are captured at start; later changes on rs1_data/rs2_data/rd_in have no effect.
- done and a register-file RegWrite from another path never coincide, because stall holds the pipeline.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - special-case constants (DIV_ZERO_Q all ones, DIV_OVF_Q 0x80000000).
- One natural sub-module: muldiv_datapath. It holds the shift/accumulate registers and one add/subtract per cycle, shared by multiply and divide.
- muldiv_unit keeps the FSM, counter, sign handling, and special-case detection.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done exactly 33 cycles after start, result=0xFFFFFFEB, rd_out=rd_in; stall high until done.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 10/0 -> 0xFFFFFFFF with done after 1 cycle. REMU 10/0 -> 10. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0.
- Reset pulsed low at cycle 10 of a MUL -> busy=0, result=0, no done pulse. A following MUL 3×5 completes normally with result 15.
- Second start (different rd) at cycle 5 of a DIVU -> ignored. Single done with the first result and first rd_out; changing rs1_data mid-run does not alter the result.
